// File: rtl/bram_dp_param.sv
// bram_dp_param: dual-port word RAM, port A read/write with byte enables, port B read-only,
// post-reset clear sequencer, out-of-range flags, 1- or 2-cycle read latency. Macro: BRAM_WR_FWD_EN.
module bram_dp_param #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 11,
  parameter int RD_LATENCY = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN_A,
  input  logic [DATA_WIDTH/8-1:0] WE_A,
  input  logic [ADDR_WIDTH-1:0]   A_A,
  input  logic [DATA_WIDTH-1:0]   Di_A,
  output logic [DATA_WIDTH-1:0]   Do_A,
  input  logic                    EN_B,
  input  logic [ADDR_WIDTH-1:0]   A_B,
  output logic [DATA_WIDTH-1:0]   Do_B,
  output logic                    ready,
  output logic                    oor_A,
  output logic                    oor_B
);

  localparam int NB        = DATA_WIDTH / 8;
  localparam int LANE_BITS = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W     = ADDR_WIDTH - LANE_BITS;
  localparam int MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0]    DEPTH_X  = (IDX_W + 1)'(DEPTH);
  localparam logic [MEM_AW-1:0] LAST_IDX = MEM_AW'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state_q, state_d;
  logic [MEM_AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic                ready_q, ready_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]    idx_a, idx_b;
  logic                in_rng_a, in_rng_b;
  logic                acc_a, acc_b, wr_user;

  logic [MEM_AW-1:0]     wr_idx;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic                  oor_a_q, oor_a_d, oor_b_q, oor_b_d;

  assign idx_a    = A_A[ADDR_WIDTH-1:LANE_BITS];
  assign idx_b    = A_B[ADDR_WIDTH-1:LANE_BITS];
  assign in_rng_a = ({1'b0, idx_a} < DEPTH_X);
  assign in_rng_b = ({1'b0, idx_b} < DEPTH_X);
  assign acc_a    = ready_q & EN_A;
  assign acc_b    = ready_q & EN_B;
  assign wr_user  = acc_a & in_rng_a;

  if (LANE_BITS > 0) begin : g_lane_unused
    logic unused_lane_bits;
    assign unused_lane_bits = ^{A_A[LANE_BITS-1:0], A_B[LANE_BITS-1:0]};
  end

  // Clear sequencer: one word per cycle, RUN entered together with the last clear write.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + MEM_AW'(1);
      if (clr_cnt_q == LAST_IDX) begin
        state_d = RUN;
        ready_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Single write port shared by the clear sequencer and port A.
  always_comb begin
    wr_idx  = clr_cnt_q;
    wr_be   = '0;
    wr_data = '0;
    if (!RST) begin
      if (state_q == CLEAR) begin
        wr_be = '1;
      end else if (wr_user) begin
        wr_idx  = idx_a[MEM_AW-1:0];
        wr_be   = WE_A;
        wr_data = Di_A;
      end
    end
  end

  // NOTE: the array has no reset branch; the CLEAR sequence is what zeroes it.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // First read stage: data holds when idle, the flag is a one-cycle pulse per access.
  always_comb begin
    rd_a_d  = rd_a_q;
    oor_a_d = 1'b0;
    if (acc_a) begin
      rd_a_d  = in_rng_a ? mem_q[idx_a[MEM_AW-1:0]] : '0;
      oor_a_d = ~in_rng_a;
    end
  end

  always_comb begin
    rd_b_d  = rd_b_q;
    oor_b_d = 1'b0;
    if (acc_b) begin
      rd_b_d  = '0;
      oor_b_d = ~in_rng_b;
      if (in_rng_b) begin
        rd_b_d = mem_q[idx_b[MEM_AW-1:0]];
`ifdef BRAM_WR_FWD_EN
        if (wr_user && (idx_a == idx_b)) begin
          for (int i = 0; i < NB; i++) begin
            if (WE_A[i]) rd_b_d[8*i +: 8] = Di_A[8*i +: 8];
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      oor_a_q <= 1'b0;
      oor_b_q <= 1'b0;
    end else begin
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      oor_a_q <= oor_a_d;
      oor_b_q <= oor_b_d;
    end
  end

  if (RD_LATENCY >= 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rd_a2_q, rd_b2_q;
    logic                  oor_a2_q, oor_b2_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        rd_a2_q  <= '0;
        rd_b2_q  <= '0;
        oor_a2_q <= 1'b0;
        oor_b2_q <= 1'b0;
      end else begin
        rd_a2_q  <= rd_a_q;
        rd_b2_q  <= rd_b_q;
        oor_a2_q <= oor_a_q;
        oor_b2_q <= oor_b_q;
      end
    end

    assign Do_A  = rd_a2_q;
    assign Do_B  = rd_b2_q;
    assign oor_A = oor_a2_q;
    assign oor_B = oor_b2_q;
  end else begin : g_lat1
    assign Do_A  = rd_a_q;
    assign Do_B  = rd_b_q;
    assign oor_A = oor_a_q;
    assign oor_B = oor_b_q;
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_bram_dp_param.sv
// Directed bench for bram_dp_param: one instance at read latency 1, one at latency 2, shared stimulus.
module tb_bram_dp_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en_a, en_b;
  logic [3:0]  we_a;
  logic [11:0] a_a, a_b;
  logic [31:0] di_a;

  logic [31:0] do_a1, do_b1, do_a2, do_b2;
  logic        rdy1, rdy2, oor_a1, oor_b1, oor_a2, oor_b2;

  int n_cmp = 0;
  int n_err = 0;

`ifdef BRAM_WR_FWD_EN
  localparam logic [31:0] COL_EXP = 32'h55;
`else
  localparam logic [31:0] COL_EXP = 32'h5;
`endif

  bram_dp_param #(.RD_LATENCY(1)) dut1 (
    .CLK(clk), .RST(rst), .EN_A(en_a), .WE_A(we_a), .A_A(a_a), .Di_A(di_a), .Do_A(do_a1),
    .EN_B(en_b), .A_B(a_b), .Do_B(do_b1), .ready(rdy1), .oor_A(oor_a1), .oor_B(oor_b1)
  );

  bram_dp_param #(.RD_LATENCY(2)) dut2 (
    .CLK(clk), .RST(rst), .EN_A(en_a), .WE_A(we_a), .A_A(a_a), .Di_A(di_a), .Do_A(do_a2),
    .EN_B(en_b), .A_B(a_b), .Do_B(do_b2), .ready(rdy2), .oor_A(oor_a2), .oor_B(oor_b2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ea, input logic [3:0] we, input logic [11:0] aa,
                       input logic [31:0] d, input logic eb, input logic [11:0] ab);
    en_a = ea; we_a = we; a_a = aa; di_a = d; en_b = eb; a_b = ab;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 12'h000);
  endtask

  task automatic access(input logic ea, input logic [3:0] we, input logic [11:0] aa,
                        input logic [31:0] d, input logic eb, input logic [11:0] ab);
    drive(ea, we, aa, d, eb, ab);
    tick();
    idle();
  endtask

  // RST must already be low; the caller chooses what is driven on the ports during clear.
  task automatic run_clear(input string tag);
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) begin
        check({tag, "_ready_early"}, 32'(rdy1), 32'd0);
        check({tag, "_do_a_held"}, do_a1, 32'd0);
      end
      if (k == 11) begin
        check({tag, "_ready"}, 32'(rdy1), 32'd1);
        check({tag, "_ready_l2"}, 32'(rdy2), 32'd1);
        idle();
      end
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i <= 10; i++) begin
      access(1'b1, 4'h0, 12'(4 * i), 32'h0, 1'b1, 12'(4 * (10 - i)));
      check({tag, "_a"}, do_a1, 32'd0);
      check({tag, "_b"}, do_b1, 32'd0);
      tick();
      check({tag, "_a2"}, do_a2, 32'd0);
    end
  endtask

  logic [31:0] model [11];

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    check("rst_ready", 32'(rdy1), 32'd0);
    check("rst_do_a", do_a1, 32'd0);
    check("rst_do_b", do_b1, 32'd0);
    check("rst_oor_a", 32'(oor_a1), 32'd0);
    check("rst_oor_b2", 32'(oor_b2), 32'd0);

    // Requests during clear must be ignored.
    rst = 1'b0;
    drive(1'b1, 4'hF, 12'h000, 32'hFFFF_FFFF, 1'b1, 12'h000);
    run_clear("clr0");
    read_all_zero("clr0_rd");

    for (int i = 0; i <= 10; i++) begin
      access(1'b1, 4'hF, 12'(4 * i), 32'(i), 1'b0, 12'h000);
      model[i] = 32'(i);
    end

    for (int i = 0; i <= 10; i++) begin
      access(1'b1, 4'h0, 12'(4 * i), 32'h0, 1'b1, 12'(4 * (10 - i)));
      check("rb_a", do_a1, 32'(i));
      check("rb_oor_a", 32'(oor_a1), 32'd0);
      check("rb_b", do_b1, 32'(10 - i));
      check("rb_a2_lag", do_a2, (i == 0) ? 32'd0 : 32'(i - 1));
      tick();
      check("rb_a2", do_a2, 32'(i));
      check("rb_b2", do_b2, 32'(10 - i));
    end

    access(1'b1, 4'hF, 12'h00C, 32'h1122_3344, 1'b0, 12'h000);
    check("be_read_first", do_a1, 32'd3);
    access(1'b1, 4'b0101, 12'h00C, 32'hAABB_CCDD, 1'b0, 12'h000);
    check("be_read_first2", do_a1, 32'h1122_3344);
    access(1'b1, 4'h0, 12'h00C, 32'h0, 1'b1, 12'h00C);
    check("be_a", do_a1, 32'h11BB_33DD);
    check("be_b", do_b1, 32'h11BB_33DD);
    tick();
    check("hold_a", do_a1, 32'h11BB_33DD);
    model[3] = 32'h11BB_33DD;

    access(1'b1, 4'hF, 12'h02C, 32'hDEAD_BEEF, 1'b1, 12'hFFC);
    check("oor_a", 32'(oor_a1), 32'd1);
    check("oor_do_a", do_a1, 32'd0);
    check("oor_b", 32'(oor_b1), 32'd1);
    check("oor_do_b", do_b1, 32'd0);
    check("oor_a2_lag", 32'(oor_a2), 32'd0);
    tick();
    check("oor_a_pulse", 32'(oor_a1), 32'd0);
    check("oor_a2", 32'(oor_a2), 32'd1);
    check("oor_do_a2", do_a2, 32'd0);
    check("oor_b2", 32'(oor_b2), 32'd1);
    tick();
    check("oor_a2_pulse", 32'(oor_a2), 32'd0);
    for (int i = 0; i <= 10; i++) begin
      access(1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'(4 * i));
      check("oor_keep", do_b1, model[i]);
    end

    access(1'b1, 4'hF, 12'h014, 32'h5, 1'b0, 12'h000);
    access(1'b1, 4'hF, 12'h014, 32'h55, 1'b1, 12'h014);
    check("col_b", do_b1, COL_EXP);
    check("col_a", do_a1, 32'h5);
    tick();
    check("col_b2", do_b2, COL_EXP);
    access(1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'h014);
    check("col_after", do_b1, 32'h55);

    // Reset again when the clear counter has reached 4.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    check("rst_clr_ready", 32'(rdy1), 32'd0);
    rst = 1'b0;
    run_clear("clr1");
    read_all_zero("clr1_rd");

    access(1'b1, 4'hF, 12'h01C, 32'h77, 1'b0, 12'h000);
    access(1'b1, 4'h0, 12'h01C, 32'h0, 1'b1, 12'h01C);
    check("run_rd_a", do_a1, 32'h77);
    tick();
    rst = 1'b1;
    tick();
    check("rst_run_ready", 32'(rdy1), 32'd0);
    check("rst_run_do_a", do_a1, 32'd0);
    check("rst_run_do_b", do_b1, 32'd0);
    check("rst_run_do_a2", do_a2, 32'd0);
    check("rst_run_do_b2", do_b2, 32'd0);
    rst = 1'b0;
    run_clear("clr2");
    read_all_zero("clr2_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
